pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch requester; consumes the 2-bit PCSrc
//  produced by the branch logic and turns it into the next fetch address.
//  Sits between branch logic / ALU / immediate extender and the instruction memory port.
//  Holds redirects that arrive while the fetch port is busy, and traps on misaligned targets.
// PARAMETERS
//  XLEN      32            datapath and address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk            in   1     system clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  PCSrc          in   2     00 PC+4, 01 PC+immExt (branch/jal), 10 aluResult (jalr), 11 reserved
//  immExt         in   XLEN  sign-extended immediate of current instruction
//  aluResult      in   XLEN  jalr target (rs1+imm)
//  stall          in   1     hold PC and suppress fetch request
//  imem_req_ready in   1     instruction memory accepts request this cycle
//  imem_req_valid out  1     fetch request valid
//  imem_addr      out  XLEN  fetch address (= PC)
//  PC             out  XLEN  current program counter
//  PCPlus4        out  XLEN  PC + 4 (link value for jal/jalr)
//  PCTarget       out  XLEN  PC + immExt
//  flush          out  1     one-cycle pulse: PC was redirected last edge
//  misaligned     out  1     sticky: a taken target had bits [1:0] != 0
// BEHAVIOUR
//  - States: BOOT -> FETCH -> TRAP. Reset (async) forces BOOT, PC=RESET_PC, pend_valid=0,
//    flush=0, misaligned=0, imem_req_valid=0. BOOT lasts exactly one cycle, then FETCH.
//  - FETCH: imem_req_valid = ~stall. Handshake = imem_req_valid & imem_req_ready.
//  - Target select: PCSrc=01 -> PC+immExt; 10 -> {aluResult[XLEN-1:1],1'b0}; 11 treated as 00.
//    All sums modulo 2^XLEN (wrap, no overflow flag). PCPlus4/PCTarget combinational from PC.
//  - Redirect = PCSrc in {01,10}. On handshake edge: if redirect, PC<=target; else if
//    pend_valid, PC<=pend_target; else PC<=PCPlus4. pend_valid cleared on any handshake.
//  - Redirect with no handshake (stall or ~ready): pend_target<=target, pend_valid<=1; PC holds.
//    A newer redirect overwrites an older pending one (latest wins).
//  - flush=1 for exactly the cycle after an edge that loaded a redirect or pending target.
//  - Misalignment: any selected redirect target with [1:0]!=0 -> next state TRAP,
//    misaligned<=1, PC not updated, pend cleared. Checked whether or not handshake occurs.
//  - TRAP: imem_req_valid=0, PC frozen, misaligned held at 1, inputs ignored; exit only via reset.
//  - stall has priority over ready: no request, no PC update, pending logic still active.
//  - Reset mid-operation discards pending redirect immediately (asynchronous).
//  - Latency: PCSrc sampled at edge N, imem_addr shows target in cycle N+1.
// TESTING
//  1 reset, ready=1, PCSrc=00 -> BOOT 1 cycle, then imem_addr 0,4,8,12 on successive cycles.
//  2 PC=0x10, PCSrc=01, immExt=0xFFFF_FFF8 -> next PC=0x08, flush=1 one cycle, PCPlus4 was 0x14.
//  3 PCSrc=10, aluResult=0x0000_0105 -> misaligned=1? no: target 0x104 (lsb cleared) loaded;
//    aluResult=0x0000_0106 -> TRAP, misaligned=1, imem_req_valid=0 until reset.
//  4 PC=0x20, ready=0 two cycles, PCSrc=01 imm=0x40 in cycle 1 then 00 -> on first ready PC=0x60.
//  5 stall=1 with redirects imm=0x8 then imm=0x100 -> after release PC=PC0+0x100 (latest wins).
//  6 PC=0xFFFF_FFFC, PCSrc=00, ready=1 -> PC wraps to 0x0000_0000, no flags raised.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and instruction-fetch requester
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] aluResult,
    input  logic            stall,
    input  logic            imem_req_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] PCTarget,
    output logic            flush,
    output logic            misaligned
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_TRAP  = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_target;
    logic            pend_valid;
    logic            flush_q;
    logic            mis_q;

    logic [XLEN-1:0] target;
    logic            redirect;
    logic            bad_target;
    logic            handshake;

    assign PC         = pc_q;
    assign imem_addr  = pc_q;
    assign PCPlus4    = pc_q + XLEN'(4);
    assign PCTarget   = pc_q + immExt;
    assign flush      = flush_q;
    assign misaligned = mis_q;

    // Redirect target selection; jalr clears bit 0, reserved encoding behaves as sequential
    always_comb begin
        target   = PCTarget;
        redirect = 1'b0;
        case (PCSrc)
            2'b01: begin
                target   = PCTarget;
                redirect = 1'b1;
            end
            2'b10: begin
                target   = aluResult & ~{{(XLEN-1){1'b0}}, 1'b1};
                redirect = 1'b1;
            end
            default: begin
                target   = PCTarget;
                redirect = 1'b0;
            end
        endcase
        bad_target = redirect && (target[1:0] != 2'b00);
    end

    assign imem_req_valid = (state == S_FETCH) && !stall;
    assign handshake      = imem_req_valid && imem_req_ready;

    // Sequencing: PC advance, redirect hold-over, misalignment trap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_BOOT;
            pc_q        <= RESET_PC;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            flush_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bad_target) begin
                        state      <= S_TRAP;
                        mis_q      <= 1'b1;
                        pend_valid <= 1'b0;
                    end else if (handshake) begin
                        pend_valid <= 1'b0;
                        if (redirect) begin
                            pc_q    <= target;
                            flush_q <= 1'b1;
                        end else if (pend_valid) begin
                            pc_q    <= pend_target;
                            flush_q <= 1'b1;
                        end else begin
                            pc_q <= PCPlus4;
                        end
                    end else if (redirect) begin
                        // Latest redirect wins over any older held one
                        pend_target <= target;
                        pend_valid  <= 1'b1;
                    end
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
